score_link: RTL and testbench
=============================

Name: score_link

Overview:
- Framed score exchange between two boards over one byte-wide UART channel.
- Replaces the free-running byte streamer and the receive mux for one link.
- Periodically snapshots the local 6-digit BCD score and sends it as a checksummed 6-byte frame.
- Parses incoming frames and publishes the validated remote score for the character ROM.
- Sits between the score BCD converter/char ROM and the uart instance.

Parameters:
- PERIOD, 750000, pclk cycles between frame launches (10 ms at 75 MHz); minimum 16.
- TIMEOUT, 75000, pclk cycles allowed between received bytes of one frame before the parser resynchronises.
- PLAYER_ID, 8'h01, ID byte placed in transmitted frames.

Ports:
- pclk  in  1  pixel clock, 75 MHz, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- points  in  24  local score, 6 BCD digits.
- tx_done_tick  in  1  one-cycle pulse from the uart: current tx byte finished.
- rx_done_tick  in  1  one-cycle pulse from the uart: r_data valid.
- r_data  in  8  received byte.
- tx_data  out  8  byte to the uart transmitter.
- wr_uart  out  1  one-cycle write strobe to the uart.
- ext_data  out  24  last valid remote score (BCD).
- ext_id  out  8  ID byte of the last valid remote frame.
- link_ok  out  1  high while a valid frame has arrived within the last 4*PERIOD cycles.
- crc_err_cnt  out  8  saturating count of frames with a bad checksum.

Behaviour:
- Frame format, 6 bytes, in order:
  - 8'hA5 header
  - ID
  - points[23:16]
  - points[15:8]
  - points[7:0]
  - CHK = XOR of bytes 1..4.
- Reset values:
  - tx_data=8'h00, wr_uart=0
  - ext_data=24'h000000, ext_id=8'h00
  - link_ok=0, crc_err_cnt=0
  - all counters 0; TX FSM in IDLE, RX FSM in HUNT.
- TX FSM states:
  - IDLE: period counter counts to PERIOD-1, then latches points into a snapshot register and goes to LOAD with byte index 0. The points value shown in the frame is the one from that cycle; later changes do not alter the frame.
  - LOAD: drives tx_data = frame byte[idx] and pulses wr_uart for exactly one cycle, then goes to WAIT.
  - WAIT: on tx_done_tick, if idx==5 go to IDLE, else idx+1 and go to LOAD. Ticks that arrive in IDLE or LOAD are ignored.
- tx_data holds its value between strobes.
- The period counter keeps running during a frame. If a period expires while not in IDLE, that launch is dropped (no queueing) and the counter wraps normally.
- RX FSM states:
  - HUNT: on a tick with r_data==8'hA5, go to ID, else stay.
  - ID, B2, B1, B0, CHK: capture one byte per tick into a shadow register, updating a running XOR.
  - In CHK: if the running XOR == r_data, then on the next cycle ext_data/ext_id update atomically from the shadow register and link_ok's timer reloads. If it does not match, crc_err_cnt increments (saturating at 255) and the outputs keep their old values. Either way, return to HUNT.
- A 8'hA5 received mid-frame is treated as data, not a resync.
- The inter-byte timer resets on every rx_done_tick while outside HUNT. When it reaches TIMEOUT, the parser returns to HUNT, the partial frame is discarded, and no error is counted.
- link_ok timer:
  - reloads to 4*PERIOD on each valid frame and decrements to 0;
  - link_ok = (timer != 0).
- TX and RX are independent; simultaneous tx_done_tick and rx_done_tick are both serviced in the same cycle.
- If reset is asserted mid-frame, everything returns to reset values immediately. The uart may finish a byte already in flight; its tx_done_tick after reset is ignored because the TX FSM is in IDLE.
- Latency: wr_uart for byte 0 is asserted 1 cycle after the period expires.

Test Plan:
- Reset then idle, PERIOD=16, points=24'h012345, uart model returns tx_done_tick 10 cycles after each wr_uart -> exactly 6 strobes with bytes A5,01,01,23,45,66; next frame starts at the following period boundary.
- Feed RX bytes A5,07,00,09,87,(07^00^09^87=89) -> ext_data=24'h000987 and ext_id=8'h07 one cycle after the last tick; link_ok=1; drops to 0 after 4*PERIOD cycles with no further frames.
- Same frame with CHK=8'h88 -> ext_data unchanged, crc_err_cnt 0->1; 300 bad frames -> counter holds 255.
- Send A5,07,00 then stall TIMEOUT cycles, then a full valid frame -> first partial frame discarded without an error count; second frame accepted.
- Change points during WAIT of byte 2 -> bytes 3..5 still carry the snapshot value, checksum is consistent; hold tx_done_tick low for 2*PERIOD -> no second frame starts and no extra strobe appears.
- Assert rst low during RX state B1 and TX state WAIT -> all outputs take reset values asynchronously; after release, the next valid frame is parsed correctly from HUNT.

Source files
------------

// File: rtl/score_link.sv
`default_nettype none
// ============================================================================
// Module      : score_link
// Description : Framed, checksummed 6-digit BCD score exchange over one UART
//               byte channel: periodic transmit plus validating receive parser.
// Revision    : 1.0 - initial release
// ============================================================================
module score_link #(
    parameter int         PERIOD    = 750000,
    parameter int         TIMEOUT   = 75000,
    parameter logic [7:0] PLAYER_ID = 8'h01
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [23:0] points,
    input  logic        tx_done_tick,
    input  logic        rx_done_tick,
    input  logic [7:0]  r_data,
    output logic [7:0]  tx_data,
    output logic        wr_uart,
    output logic [23:0] ext_data,
    output logic [7:0]  ext_id,
    output logic        link_ok,
    output logic [7:0]  crc_err_cnt
);

    localparam int c_PER_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int c_LINK_W = $clog2(4 * PERIOD + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [c_PER_W-1:0]  c_PER_LAST  = c_PER_W'(PERIOD - 1);
    localparam logic [c_PER_W-1:0]  c_PER_ONE   = c_PER_W'(1);
    localparam logic [c_LINK_W-1:0] c_LINK_LOAD = c_LINK_W'(4 * PERIOD);
    localparam logic [c_LINK_W-1:0] c_LINK_ONE  = c_LINK_W'(1);
    localparam logic [c_TO_W-1:0]   c_TO_LIMIT  = c_TO_W'(TIMEOUT);
    localparam logic [c_TO_W-1:0]   c_TO_ONE    = c_TO_W'(1);
    localparam logic [7:0]          c_HDR       = 8'hA5;

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_WAIT} tx_state_t;
    typedef enum logic [2:0] {RX_HUNT, RX_ID, RX_B2, RX_B1, RX_B0, RX_CHK} rx_state_t;

    tx_state_t           r_tx_state, w_tx_next;
    rx_state_t           r_rx_state, w_rx_next;
    logic [c_PER_W-1:0]  r_per_cnt;
    logic                w_per_hit;
    logic [2:0]          r_idx;
    logic [23:0]         r_snap;
    logic [7:0]          r_tx_hold;
    logic [7:0]          w_tx_byte;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                w_timeout;
    logic [7:0]          r_sh_id;
    logic [23:0]         r_sh_data;
    logic [7:0]          r_xor;
    logic                w_chk_tick;
    logic                w_frame_ok;
    logic                w_frame_bad;
    logic [c_LINK_W-1:0] r_link_cnt;

    // ---------------------------------------------------------------- transmit
    // Period counter free-runs; launches that land outside IDLE are dropped.
    assign w_per_hit = (r_per_cnt == c_PER_LAST);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_per_cnt <= '0;
        end else if (w_per_hit) begin
            r_per_cnt <= '0;
        end else begin
            r_per_cnt <= r_per_cnt + c_PER_ONE;
        end
    end

    always_comb begin
        case (r_idx)
            3'd0:    w_tx_byte = c_HDR;
            3'd1:    w_tx_byte = PLAYER_ID;
            3'd2:    w_tx_byte = r_snap[23:16];
            3'd3:    w_tx_byte = r_snap[15:8];
            3'd4:    w_tx_byte = r_snap[7:0];
            default: w_tx_byte = PLAYER_ID ^ r_snap[23:16] ^ r_snap[15:8] ^ r_snap[7:0];
        endcase
    end

    always_comb begin
        w_tx_next = r_tx_state;
        wr_uart   = 1'b0;
        tx_data   = r_tx_hold;
        case (r_tx_state)
            TX_IDLE: begin
                if (w_per_hit) begin
                    w_tx_next = TX_LOAD;
                end
            end
            TX_LOAD: begin
                wr_uart   = 1'b1;
                tx_data   = w_tx_byte;
                w_tx_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done_tick) begin
                    w_tx_next = (r_idx == 3'd5) ? TX_IDLE : TX_LOAD;
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_idx      <= 3'd0;
            r_snap     <= 24'h000000;
            r_tx_hold  <= 8'h00;
        end else begin
            r_tx_state <= w_tx_next;
            if (r_tx_state == TX_IDLE && w_per_hit) begin
                r_snap <= points;
                r_idx  <= 3'd0;
            end
            if (r_tx_state == TX_LOAD) begin
                r_tx_hold <= w_tx_byte;
            end
            if (r_tx_state == TX_WAIT && tx_done_tick && r_idx != 3'd5) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // ----------------------------------------------------------------- receive
    assign w_timeout   = (r_rx_state != RX_HUNT) && (r_to_cnt == c_TO_LIMIT);
    assign w_chk_tick  = rx_done_tick && (r_rx_state == RX_CHK);
    assign w_frame_ok  = w_chk_tick && (r_xor == r_data);
    assign w_frame_bad = w_chk_tick && (r_xor != r_data);

    always_comb begin
        w_rx_next = r_rx_state;
        if (rx_done_tick) begin
            case (r_rx_state)
                RX_HUNT: if (r_data == c_HDR) w_rx_next = RX_ID;
                RX_ID:   w_rx_next = RX_B2;
                RX_B2:   w_rx_next = RX_B1;
                RX_B1:   w_rx_next = RX_B0;
                RX_B0:   w_rx_next = RX_CHK;
                default: w_rx_next = RX_HUNT;
            endcase
        end else if (w_timeout) begin
            w_rx_next = RX_HUNT;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_HUNT;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    // Inter-byte timer idles at zero in HUNT and saturates at the limit.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (r_rx_state == RX_HUNT || rx_done_tick) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_LIMIT) begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_sh_id     <= 8'h00;
            r_sh_data   <= 24'h000000;
            r_xor       <= 8'h00;
            ext_data    <= 24'h000000;
            ext_id      <= 8'h00;
            crc_err_cnt <= 8'h00;
            r_link_cnt  <= '0;
        end else begin
            if (rx_done_tick) begin
                case (r_rx_state)
                    RX_ID: begin
                        r_sh_id <= r_data;
                        r_xor   <= r_data;
                    end
                    RX_B2: begin
                        r_sh_data[23:16] <= r_data;
                        r_xor            <= r_xor ^ r_data;
                    end
                    RX_B1: begin
                        r_sh_data[15:8] <= r_data;
                        r_xor           <= r_xor ^ r_data;
                    end
                    RX_B0: begin
                        r_sh_data[7:0] <= r_data;
                        r_xor          <= r_xor ^ r_data;
                    end
                    default: ;
                endcase
            end
            if (w_frame_ok) begin
                ext_data <= r_sh_data;
                ext_id   <= r_sh_id;
            end
            if (w_frame_bad && crc_err_cnt != 8'hFF) begin
                crc_err_cnt <= crc_err_cnt + 8'd1;
            end
            if (w_frame_ok) begin
                r_link_cnt <= c_LINK_LOAD;
            end else if (r_link_cnt != '0) begin
                r_link_cnt <= r_link_cnt - c_LINK_ONE;
            end
        end
    end

    assign link_ok = (r_link_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_score_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_link
// Description : Directed self-checking bench for score_link.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_link;

    localparam int c_PERIOD  = 16;
    localparam int c_TIMEOUT = 40;

    logic        pclk         = 1'b0;
    logic        rst          = 1'b0;
    logic [23:0] points       = 24'h012345;
    logic        tx_done_tick = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  r_data       = 8'h00;
    logic [7:0]  tx_data;
    logic        wr_uart;
    logic [23:0] ext_data;
    logic [7:0]  ext_id;
    logic        link_ok;
    logic [7:0]  crc_err_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          dly     = 0;
    logic        tx_hold = 1'b0;
    logic [7:0]  s_byte [$];
    int          s_cyc  [$];
    int          n_before;

    score_link #(
        .PERIOD    (c_PERIOD),
        .TIMEOUT   (c_TIMEOUT),
        .PLAYER_ID (8'h01)
    ) u_dut (
        .pclk         (pclk),
        .rst          (rst),
        .points       (points),
        .tx_done_tick (tx_done_tick),
        .rx_done_tick (rx_done_tick),
        .r_data       (r_data),
        .tx_data      (tx_data),
        .wr_uart      (wr_uart),
        .ext_data     (ext_data),
        .ext_id       (ext_id),
        .link_ok      (link_ok),
        .crc_err_cnt  (crc_err_cnt)
    );

    always #5 pclk = ~pclk;

    // UART transmitter model: records strobes, answers 10 cycles later
    always @(negedge pclk) begin
        cyc++;
        tx_done_tick = 1'b0;
        if (dly != 0) begin
            dly--;
            if (dly == 0 && !tx_hold) tx_done_tick = 1'b1;
        end
        if (wr_uart) begin
            s_byte.push_back(tx_data);
            s_cyc.push_back(cyc);
            dly = 10;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget && s_byte.size() < n; i++) @(negedge pclk);
        check($sformatf("strobes>=%0d", n), 32'(s_byte.size() >= n), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge pclk);
        r_data       = b;
        rx_done_tick = 1'b1;
        @(negedge pclk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [23:0] d, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(id);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        send_byte(chk);
    endtask

    initial begin
        repeat (3) @(negedge pclk);
        check("rst tx_data", 32'(tx_data), 32'h00);
        check("rst wr_uart", 32'(wr_uart), 32'h0);
        check("rst ext_data", 32'(ext_data), 32'h000000);
        check("rst ext_id", 32'(ext_id), 32'h00);
        check("rst link_ok", 32'(link_ok), 32'h0);
        check("rst crc", 32'(crc_err_cnt), 32'h00);
        rst = 1'b1;

        // Two frames: content and launch spacing (6*11 cycles -> next boundary 80)
        wait_strobes(13, 400);
        if (s_byte.size() >= 13) begin
            check("f1 b0", 32'(s_byte[0]), 32'hA5);
            check("f1 b1", 32'(s_byte[1]), 32'h01);
            check("f1 b2", 32'(s_byte[2]), 32'h01);
            check("f1 b3", 32'(s_byte[3]), 32'h23);
            check("f1 b4", 32'(s_byte[4]), 32'h45);
            check("f1 b5", 32'(s_byte[5]), 32'h66);
            check("f2 b0", 32'(s_byte[6]), 32'hA5);
            check("f2 b5", 32'(s_byte[11]), 32'h66);
            check("f1-f2 spacing", 32'(s_cyc[6] - s_cyc[0]), 32'd80);
            check("f2-f3 spacing", 32'(s_cyc[12] - s_cyc[6]), 32'd80);
        end

        // Points change during WAIT of byte 2 of frame 3
        wait_strobes(15, 200);
        points = 24'h999999;
        wait_strobes(18, 200);
        tx_hold = 1'b1;
        if (s_byte.size() >= 18) begin
            check("snap b3", 32'(s_byte[15]), 32'h23);
            check("snap b4", 32'(s_byte[16]), 32'h45);
            check("snap chk", 32'(s_byte[17]), 32'h66);
        end
        n_before = s_byte.size();
        repeat (2 * c_PERIOD + 8) @(negedge pclk);
        check("hold no strobe", 32'(s_byte.size()), 32'(n_before));
        check("hold tx_data", 32'(tx_data), 32'h66);

        // Valid frame, then link timeout
        send_frame(8'h07, 24'h000987, 8'h89);
        check("rx1 ext_data", 32'(ext_data), 32'h000987);
        check("rx1 ext_id", 32'(ext_id), 32'h07);
        check("rx1 link_ok", 32'(link_ok), 32'h1);
        check("rx1 crc", 32'(crc_err_cnt), 32'h00);
        repeat (63) @(negedge pclk);
        check("link before drop", 32'(link_ok), 32'h1);
        @(negedge pclk);
        check("link dropped", 32'(link_ok), 32'h0);

        // Bad checksum
        send_frame(8'h07, 24'h000987, 8'h88);
        check("bad ext_data", 32'(ext_data), 32'h000987);
        check("bad crc", 32'(crc_err_cnt), 32'h01);
        check("bad link_ok", 32'(link_ok), 32'h0);

        // Partial frame discarded by inter-byte timeout
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h00);
        repeat (c_TIMEOUT + 5) @(negedge pclk);
        send_frame(8'h0B, 24'h123456, 8'h7B);
        check("to ext_data", 32'(ext_data), 32'h123456);
        check("to ext_id", 32'(ext_id), 32'h0B);
        check("to crc", 32'(crc_err_cnt), 32'h01);

        // Header value inside a frame is data
        send_frame(8'hA5, 24'h00A501, 8'h01);
        check("a5 ext_data", 32'(ext_data), 32'h00A501);
        check("a5 ext_id", 32'(ext_id), 32'hA5);

        // Error counter saturation
        for (int i = 0; i < 254; i++) send_frame(8'h07, 24'h000987, 8'h88);
        check("crc 255", 32'(crc_err_cnt), 32'hFF);
        for (int i = 0; i < 45; i++) send_frame(8'h07, 24'h000987, 8'h88);
        check("crc sat", 32'(crc_err_cnt), 32'hFF);
        check("sat ext_data", 32'(ext_data), 32'h00A501);

        // Asynchronous reset with RX in B1 and TX in WAIT
        send_byte(8'hA5);
        send_byte(8'h07);
        send_byte(8'h00);
        @(negedge pclk);
        #2 rst = 1'b0;
        #1;
        check("arst tx_data", 32'(tx_data), 32'h00);
        check("arst wr_uart", 32'(wr_uart), 32'h0);
        check("arst ext_data", 32'(ext_data), 32'h000000);
        check("arst ext_id", 32'(ext_id), 32'h00);
        check("arst link_ok", 32'(link_ok), 32'h0);
        check("arst crc", 32'(crc_err_cnt), 32'h00);
        @(negedge pclk);
        rst     = 1'b1;
        tx_hold = 1'b0;
        n_before = s_byte.size();
        send_frame(8'h07, 24'h000987, 8'h89);
        check("post ext_data", 32'(ext_data), 32'h000987);
        check("post ext_id", 32'(ext_id), 32'h07);
        check("post link_ok", 32'(link_ok), 32'h1);

        // Transmitter restarts cleanly with the new score
        wait_strobes(n_before + 6, 300);
        if (s_byte.size() >= n_before + 6) begin
            check("post tx b0", 32'(s_byte[n_before]), 32'hA5);
            check("post tx b2", 32'(s_byte[n_before + 2]), 32'h99);
            check("post tx chk", 32'(s_byte[n_before + 5]), 32'h98);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
